// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and DMA bus signals of the sprite DMA controller, grouped for oam_dma_ctrl.
// master = controller view, slave = CPU core / bus decode view.
interface oam_dma_ctrl_if;
  logic        i_cpu_valid;
  logic        i_cpu_rnw;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic [7:0]  i_bus_rdata;
  logic        o_cpu_halt;
  logic        o_bus_en;
  logic        o_bus_rnw;
  logic [15:0] o_bus_addr;
  logic [7:0]  o_bus_wdata;
  logic        o_busy;

  modport master (
    input  i_cpu_valid, i_cpu_rnw, i_cpu_addr, i_cpu_wdata, i_bus_rdata,
    output o_cpu_halt, o_bus_en, o_bus_rnw, o_bus_addr, o_bus_wdata, o_busy
  );

  modport slave (
    output i_cpu_valid, i_cpu_rnw, i_cpu_addr, i_cpu_wdata, i_bus_rdata,
    input  o_cpu_halt, o_bus_en, o_bus_rnw, o_bus_addr, o_bus_wdata, o_busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA initiator: a CPU write to TRIG_ADDR copies page {P,00..FF} into OAM_ADDR.
// Define OAM_DMA_ALIGN_EN to compile in cycle-parity tracking and the ALIGN state.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic           i_clk_cpu,
  input  logic           i_rst_n,
  oam_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
    S_ALIGN = 3'd2,
`endif
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  page_r, page_s;
  logic [7:0]  idx_r, idx_s;
  logic [7:0]  latch_r, latch_s;
  logic        trigger_s;
  logic        halt_s;
  logic        bus_en_s;
  logic        bus_rnw_s;
  logic [15:0] bus_addr_s;
  logic [7:0]  bus_wdata_s;

`ifdef OAM_DMA_ALIGN_EN
  logic par_r;

  // Free-running cycle parity; READ must land on even cycles
  always_ff @(posedge i_clk_cpu or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_r <= 1'b0;
    end else begin
      par_r <= ~par_r;
    end
  end
`endif

  assign trigger_s = bus.i_cpu_valid && !bus.i_cpu_rnw && (bus.i_cpu_addr == TRIG_ADDR);

  // State and transfer registers
  always_ff @(posedge i_clk_cpu or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      page_r  <= 8'h00;
      idx_r   <= 8'h00;
      latch_r <= 8'h00;
    end else begin
      state_r <= state_s;
      page_r  <= page_s;
      idx_r   <= idx_s;
      latch_r <= latch_s;
    end
  end

  // Next-state logic; triggers are only honoured in IDLE
  always_comb begin
    state_s = state_r;
    page_s  = page_r;
    idx_s   = idx_r;
    latch_s = latch_r;
    case (state_r)
      S_IDLE: begin
        if (trigger_s) begin
          page_s  = bus.i_cpu_wdata;
          idx_s   = 8'h00;
          state_s = S_HALT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        if (par_r) begin
          state_s = S_READ;
        end else begin
          state_s = S_ALIGN;
        end
`else
        state_s = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: begin
        state_s = S_READ;
      end
`endif
      S_READ: begin
        latch_s = bus.i_bus_rdata;
        state_s = S_WRITE;
      end
      S_WRITE: begin
        // idx never wraps into the next page; the last byte ends the transfer
        if (idx_r == 8'hFF) begin
          state_s = S_IDLE;
        end else begin
          idx_s   = idx_r + 8'd1;
          state_s = S_READ;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Bus outputs decoded purely from registered state so reset drops them at once
  always_comb begin
    halt_s      = (state_r != S_IDLE);
    bus_en_s    = 1'b0;
    bus_rnw_s   = 1'b1;
    bus_addr_s  = 16'h0000;
    bus_wdata_s = 8'h00;
    case (state_r)
      S_READ: begin
        bus_en_s   = 1'b1;
        bus_addr_s = {page_r, idx_r};
      end
      S_WRITE: begin
        bus_en_s    = 1'b1;
        bus_rnw_s   = 1'b0;
        bus_addr_s  = OAM_ADDR;
        bus_wdata_s = latch_r;
      end
      default: begin
        bus_en_s = 1'b0;
      end
    endcase
  end

  assign bus.o_cpu_halt  = halt_s;
  assign bus.o_busy      = halt_s;
  assign bus.o_bus_en    = bus_en_s;
  assign bus.o_bus_rnw   = bus_rnw_s;
  assign bus.o_bus_addr  = bus_addr_s;
  assign bus.o_bus_wdata = bus_wdata_s;

endmodule
